// File: rtl/sparc_mem_ctrl_if.sv
// Control Unit <-> memory controller bundle: request fields, load result and the
// four-phase Enable/MFC handshake with store/load fault reporting.
interface sparc_mem_ctrl_if;
    logic        Enable;
    logic [5:0]  OpCode;
    logic [31:0] MAR_Address;
    logic [63:0] MDR_DataIn;
    logic [63:0] MDR_DataOut;
    logic        MFC;
    logic        MSET;
    logic        MLET;
    logic        Busy;

    modport master (
        output Enable, OpCode, MAR_Address, MDR_DataIn,
        input  MDR_DataOut, MFC, MSET, MLET, Busy
    );

    modport slave (
        input  Enable, OpCode, MAR_Address, MDR_DataIn,
        output MDR_DataOut, MFC, MSET, MLET, Busy
    );
endinterface

// File: rtl/sparc_mem_ctrl.sv
// Byte-addressed big-endian memory with programmable wait states, 32-bit beats
// (two for doublewords) and alignment/range fault checking at request acceptance.
module sparc_mem_ctrl #(
    parameter int ADDR_BITS   = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            Clk,
    input  logic            Reset_n,
    sparc_mem_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACCESS = 2'd2, S_DONE = 2'd3} state_t;
    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_t;

    typedef struct packed {
        logic  valid;
        logic  store;
        logic  sext;
        size_t size;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] op);
        dec_t d;
        d.valid = 1'b1;
        d.store = 1'b0;
        d.sext  = 1'b0;
        d.size  = SZ_W;
        case (op)
            6'b000000: d.size = SZ_W;
            6'b000001: d.size = SZ_B;
            6'b000010: d.size = SZ_H;
            6'b000011: d.size = SZ_D;
            6'b001001: begin d.size = SZ_B; d.sext = 1'b1; end
            6'b001010: begin d.size = SZ_H; d.sext = 1'b1; end
            6'b000100: begin d.size = SZ_W; d.store = 1'b1; end
            6'b000101: begin d.size = SZ_B; d.store = 1'b1; end
            6'b000110: begin d.size = SZ_H; d.store = 1'b1; end
            6'b000111: begin d.size = SZ_D; d.store = 1'b1; end
            default:   d.valid = 1'b0;
        endcase
        return d;
    endfunction

    // Last byte touched is computed 33 bits wide so addresses near 2^32 cannot wrap past the check.
    function automatic logic range_or_align_fault(input size_t sz, input logic [31:0] a);
        logic [32:0] last;
        logic        misal;
        case (sz)
            SZ_B:    begin last = {1'b0, a};          misal = 1'b0;   end
            SZ_H:    begin last = {1'b0, a} + 33'd1;  misal = a[0];   end
            SZ_W:    begin last = {1'b0, a} + 33'd3;  misal = |a[1:0]; end
            SZ_D:    begin last = {1'b0, a} + 33'd7;  misal = |a[2:0]; end
            default: begin last = {1'b0, a};          misal = 1'b1;   end
        endcase
        return misal || (last > 33'(DEPTH - 1));
    endfunction

    logic [7:0]           mem_q [DEPTH];
    state_t               state_q;
    logic [3:0]           cnt_q;
    logic                 beat_q;
    logic                 st_q, sx_q;
    size_t                sz_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [63:0]          din_q, dout_q;
    logic                 mfc_q, mset_q, mlet_q, busy_q;
    logic                 pend_st_q, pend_ld_q;

    dec_t                 dec_s;
    logic                 fault_s;
    logic [ADDR_BITS-1:0] ba0_s, ba1_s, ba2_s, ba3_s;
    logic [31:0]          rd_s, ld_s, wd_s;
    logic [3:0]           be_s;
    logic                 last_beat_s;

    assign dec_s   = decode(bus.OpCode);
    assign fault_s = !dec_s.valid || range_or_align_fault(dec_s.size, bus.MAR_Address);

    assign ba0_s = addr_q + ADDR_BITS'({beat_q, 2'b00});
    assign ba1_s = ba0_s + ADDR_BITS'(1);
    assign ba2_s = ba0_s + ADDR_BITS'(2);
    assign ba3_s = ba0_s + ADDR_BITS'(3);
    assign rd_s  = {mem_q[ba0_s], mem_q[ba1_s], mem_q[ba2_s], mem_q[ba3_s]};

    assign last_beat_s = (sz_q != SZ_D) || beat_q;

    // Beat data shaping: load extension, store lane placement (MSB-first) and byte enables.
    always_comb begin
        ld_s = rd_s;
        be_s = 4'b1111;
        wd_s = ((sz_q == SZ_D) && !beat_q) ? din_q[63:32] : din_q[31:0];
        case (sz_q)
            SZ_B: begin
                ld_s = sx_q ? {{24{rd_s[31]}}, rd_s[31:24]} : {24'h000000, rd_s[31:24]};
                be_s = 4'b1000;
                wd_s = {din_q[7:0], 24'h000000};
            end
            SZ_H: begin
                ld_s = sx_q ? {{16{rd_s[31]}}, rd_s[31:16]} : {16'h0000, rd_s[31:16]};
                be_s = 4'b1100;
                wd_s = {din_q[15:0], 16'h0000};
            end
            SZ_W:    ld_s = rd_s;
            SZ_D:    ld_s = rd_s;
            default: be_s = 4'b0000;
        endcase
    end

    // Byte array write port; contents deliberately survive reset.
    always_ff @(posedge Clk) begin
        if (state_q == S_ACCESS && st_q) begin
            if (be_s[3]) mem_q[ba0_s] <= wd_s[31:24];
            if (be_s[2]) mem_q[ba1_s] <= wd_s[23:16];
            if (be_s[1]) mem_q[ba2_s] <= wd_s[15:8];
            if (be_s[0]) mem_q[ba3_s] <= wd_s[7:0];
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            beat_q    <= 1'b0;
            st_q      <= 1'b0;
            sx_q      <= 1'b0;
            sz_q      <= SZ_W;
            addr_q    <= '0;
            din_q     <= 64'd0;
            dout_q    <= 64'd0;
            mfc_q     <= 1'b0;
            mset_q    <= 1'b0;
            mlet_q    <= 1'b0;
            busy_q    <= 1'b0;
            pend_st_q <= 1'b0;
            pend_ld_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.Enable) begin
                        st_q   <= dec_s.store;
                        sx_q   <= dec_s.sext;
                        sz_q   <= dec_s.size;
                        addr_q <= bus.MAR_Address[ADDR_BITS-1:0];
                        din_q  <= bus.MDR_DataIn;
                        beat_q <= 1'b0;
                        busy_q <= 1'b1;
                        cnt_q  <= 4'(WAIT_CYCLES);
                        if (fault_s) begin
                            pend_st_q <= !dec_s.valid || dec_s.store;
                            pend_ld_q <= !dec_s.valid || !dec_s.store;
                            state_q   <= S_DONE;
                        end else begin
                            pend_st_q <= 1'b0;
                            pend_ld_q <= 1'b0;
                            state_q   <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q <= 4'd1) begin
                        cnt_q   <= 4'd0;
                        state_q <= S_ACCESS;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ACCESS: begin
                    if (!st_q) begin
                        if (sz_q == SZ_D) begin
                            if (beat_q) dout_q[31:0]  <= rd_s;
                            else        dout_q[63:32] <= rd_s;
                        end else begin
                            dout_q <= {32'h00000000, ld_s};
                        end
                    end
                    if (last_beat_s) begin
                        mfc_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        beat_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Faulted requests arrive here with MFC still low and report one edge later.
                    if (!mfc_q) begin
                        mfc_q  <= 1'b1;
                        mset_q <= pend_st_q;
                        mlet_q <= pend_ld_q;
                    end else if (!bus.Enable) begin
                        mfc_q   <= 1'b0;
                        mset_q  <= 1'b0;
                        mlet_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.MDR_DataOut = dout_q;
    assign bus.MFC         = mfc_q;
    assign bus.MSET        = mset_q;
    assign bus.MLET        = mlet_q;
    assign bus.Busy        = busy_q;
endmodule

// File: doc/sparc_mem_ctrl.md
# sparc_mem_ctrl

Clocked, parametrised successor to the SPARC data/instruction RAM: a byte-addressed, big-endian memory of 2^ADDR_BITS bytes with programmable wait states, native doubleword transfers, and alignment/range checking on both loads and stores. It sits behind the MAR/MDR pair and talks to the Control Unit through a four-phase Enable/MFC handshake, reporting store faults on MSET and load faults on MLET for trap generation.

## Interface
- ADDR_BITS, 9: byte address width; memory depth is 2^ADDR_BITS bytes.
- WAIT_CYCLES, 2: wait states inserted before the first access beat; legal values are 0..15.
- Clk  in  1  single clock; all state changes on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Enable  in  1  request strobe; held high by the CU until MFC is seen.
- OpCode  in  6  operation code, sampled at request acceptance.
- MAR_Address  in  32  byte address, sampled at acceptance.
- MDR_DataIn  in  64  store data, right-justified, sampled at acceptance.
- MDR_DataOut  out  64  load result, right-justified.
- MFC  out  1  operation complete, including faulted operations.
- MSET  out  1  store error.
- MLET  out  1  load error.
- Busy  out  1  high whenever the state is not IDLE.

## Operation
- Opcodes:
  - Loads: 000000 LD word; 000001 LDUB; 000010 LDUH; 000011 LDD; 001001 LDSB; 001010 LDSH.
  - Stores: 000100 ST word; 000101 STB; 000110 STH; 000111 STD.
- Byte order is big-endian, and the byte at address A is the most significant byte.
  - Byte: Mem[A].
  - Half: {Mem[A], Mem[A+1]}.
  - Word: Mem[A..A+3].
  - Dword: [63:32] = Mem[A..A+3] and [31:0] = Mem[A+4..A+7].
- Loads narrower than a doubleword write the result into MDR_DataOut[31:0] and zero [63:32].
  - Unsigned loads zero-extend.
  - Signed loads sign-extend from bit 7 for bytes and from bit 15 for halfwords.
- Stores take the low-order bytes of MDR_DataIn: [7:0] for a byte, [15:0] for a half, [31:0] for a word, [63:0] for a doubleword.
- The following checks run at acceptance:
  - Alignment: A%2 for half, A%4 for word, A%8 for dword.
  - Range: A plus the transfer size minus 1 must not exceed 2^ADDR_BITS-1.
  - A load that fails a check sets MLET.
  - A store that fails a check sets MSET.
  - An unknown opcode sets both MLET and MSET.
  - A faulted operation never modifies memory or MDR_DataOut.
- The state machine has four states: IDLE, WAIT, ACCESS and DONE.
  - IDLE: when Enable=1, the block latches OpCode, MAR_Address and MDR_DataIn.
    - On a fault it goes to DONE with the error flag set.
    - Otherwise it goes to WAIT, or straight to ACCESS when WAIT_CYCLES=0.
  - WAIT: a counter loaded with WAIT_CYCLES decrements each cycle; when it expires the state moves to ACCESS.
  - ACCESS: one 32-bit beat per cycle, two beats for LDD/STD.
    - Writes commit at the edge that ends each beat.
    - Load data is registered into MDR_DataOut at the same edge.
    - After the last beat the state moves to DONE.
  - DONE: MFC=1, and the error flags are held at their values.
    - The block stays in DONE while Enable=1.
    - When Enable=0 the block clears MFC, MSET and MLET and returns to IDLE.
- Enable is ignored outside IDLE. The CU must drop Enable for at least one cycle between requests.

## Timing
- Reset values: MDR_DataOut=0, MFC=0, MSET=0, MLET=0, Busy=0; the state returns to IDLE and the wait counter clears. Memory contents are not reset.
- Let t be the edge at which Enable is first sampled high in IDLE; Busy is high from t onward.
- A good request raises MFC after edge t+WAIT_CYCLES+N, where N=1 for single transfers and N=2 for doublewords. MDR_DataOut is valid in the same cycle that MFC rises.
- A faulted request raises MFC together with its error flag after edge t+1.
- MFC falls after the first edge at which Enable=0 is sampled in DONE; Busy falls at that same edge.
- Reset asserted mid-operation aborts the operation immediately:
  - Before any ACCESS beat, memory is untouched.
  - Between the two STD beats, the upper word stays committed and the lower word is not written.

## Test plan
- Reset: assert Reset_n=0 with Enable=1 -> all outputs are 0 and Busy=0, and no request is accepted until Reset_n=1.
- Word and sub-word round trip (WAIT_CYCLES=2):
  - ST 0xDEADBEEF to 0x010 -> MFC rises 3 cycles after acceptance.
  - LD 0x010 -> 0xDEADBEEF.
  - LDUB 0x011 -> 0x000000AD; LDSB 0x011 -> 0xFFFFFFAD.
  - LDSH 0x012 -> 0xFFFFBEEF; LDUH 0x012 -> 0x0000BEEF.
- Doubleword: STD 0x0123456789ABCDEF to 0x020, then LDD 0x020 -> 0x0123456789ABCDEF. MFC rises 4 cycles after acceptance, and LD 0x024 -> 0x89ABCDEF.
- Faults:
  - ST to 0x012 -> MSET=1 and MFC=1 after 1 cycle, with 0x010..0x013 unchanged.
  - LDD 0x024 -> MLET=1.
  - LD 0x1FE -> MLET=1.
  - OpCode 111111 -> MSET=1 and MLET=1.
- Handshake:
  - Hold Enable high for 10 cycles after MFC -> MFC stays 1 and no new access occurs.
  - Drop Enable -> MFC and Busy clear after the next edge.
- Reset mid-operation: pulse Reset_n low during the WAIT of ST 0x55AA55AA to 0x030 -> a subsequent LD 0x030 returns the prior contents, and all outputs read 0 right after the reset.
